// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio capture path.
`timescale 1ns/1ps
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH_DEFAULT = 16;
    localparam int SYNC_STAGES              = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } i2s_rx_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous frame FIFO with registered head-of-queue output and occupancy level.
`timescale 1ns/1ps
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_n;
    logic [LVL_W-1:0] r_count;
    logic [LVL_W-1:0] w_count_n;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_n;
    logic             r_valid;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_dout  = r_dout;
    assign o_valid = r_valid;
    assign o_level = r_count;

    // Next-state decode; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        w_rd       = i_pop & r_valid;
        w_wr       = i_push & (~o_full | w_rd);
        w_rd_ptr_n = r_rd_ptr + PTR_W'(w_rd);
        w_count_n  = r_count + LVL_W'(w_wr) - LVL_W'(w_rd);
        if (w_count_n == '0) begin
            w_dout_n = r_dout;
        end else if (w_wr && (w_rd_ptr_n == r_wr_ptr)) begin
            w_dout_n = i_din;
        end else begin
            w_dout_n = r_mem[w_rd_ptr_n];
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, level and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_wr);
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_dout   <= w_dout_n;
            r_valid  <= (w_count_n != '0);
        end
    end

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S capture from the codec ADC: synchronizes the serial pins, assembles
// left/right pairs and queues them as an Avalon-ST source.
`timescale 1ns/1ps
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        audio_BCLK,
    input  logic                        audio_ADCLRCK,
    input  logic                        audio_ADCDAT,
    input  logic                        enable,
    output logic [2*DATA_WIDTH-1:0]     sample_data,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fill_level,
    output logic                        overflow,
    input  logic                        overflow_clear
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int SM    = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0]  r_bclk_sync;
    logic [SYNC_STAGES-1:0]  r_lrck_sync;
    logic [SYNC_STAGES-1:0]  r_dat_sync;
    logic                    r_bclk_d;
    logic                    r_lrck_d;
    logic                    r_bclk_rise;
    logic                    r_lrck_fall;
    logic                    r_lrck_edge;
    logic                    r_dat;

    i2s_rx_state_t           r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_left;
    logic                    r_chan;
    logic                    r_push;
    logic [2*DATA_WIDTH-1:0] r_push_data;
    logic                    r_overflow;

    logic [DATA_WIDTH-1:0]   w_shift_in;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_latch;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_drop;

    // A short word keeps its received bits in the MSBs, zero-filled below.
    function automatic logic [DATA_WIDTH-1:0] left_align(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [CNT_W-1:0]      n);
        logic [CNT_W-1:0] pad;
        pad = CNT_W'(DATA_WIDTH) - n;
        return word << pad;
    endfunction

    // Pin synchronizers plus the edge-detect stage; r_lrck_d is the new LRCK level
    // in the same cycle its edge pulse is high.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_d    <= 1'b0;
            r_bclk_rise <= 1'b0;
            r_lrck_fall <= 1'b0;
            r_lrck_edge <= 1'b0;
            r_dat       <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], audio_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], audio_ADCLRCK};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], audio_ADCDAT};
            r_bclk_d    <= r_bclk_sync[SM];
            r_lrck_d    <= r_lrck_sync[SM];
            r_bclk_rise <= r_bclk_sync[SM] & ~r_bclk_d;
            r_lrck_fall <= ~r_lrck_sync[SM] & r_lrck_d;
            r_lrck_edge <= r_lrck_sync[SM] ^ r_lrck_d;
            r_dat       <= r_dat_sync[SM];
        end
    end

    // Word completion: either the last bit arrives or LRCK cuts the channel short.
    always_comb begin
        w_shift_in = {r_shift[DATA_WIDTH-2:0], r_dat};
        w_latch    = 1'b0;
        w_word     = '0;
        if (r_state == SHIFT) begin
            if (r_lrck_edge) begin
                w_latch = 1'b1;
                w_word  = left_align(r_shift, r_cnt);
            end else if (r_bclk_rise && (r_cnt == CNT_W'(DATA_WIDTH - 1))) begin
                w_latch = 1'b1;
                w_word  = w_shift_in;
            end else begin
                w_latch = 1'b0;
            end
        end else begin
            w_latch = 1'b0;
        end
    end

    // Capture FSM and channel latches.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_chan      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else if (!enable) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_chan      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_latch) begin
                if (!r_chan) begin
                    r_left <= w_word;
                end else begin
                    r_push      <= 1'b1;
                    r_push_data <= {r_left, w_word};
                end
            end
            case (r_state)
                IDLE: begin
                    if (r_lrck_fall) begin
                        r_state <= DELAY;
                        r_chan  <= 1'b0;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                DELAY: begin
                    if (r_lrck_edge) begin
                        r_chan <= r_lrck_d;
                    end else if (r_bclk_rise) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                SHIFT: begin
                    if (r_lrck_edge) begin
                        r_state <= DELAY;
                        r_chan  <= r_lrck_d;
                    end else if (r_bclk_rise) begin
                        r_shift <= w_shift_in;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_lrck_edge) begin
                        r_state <= DELAY;
                        r_chan  <= r_lrck_d;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_pop  = sample_valid & sample_ready;
    assign w_drop = r_push & w_full & ~w_pop;

    // Sticky drop flag; a new drop outranks a same-cycle clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

    audio_sample_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_push  (r_push),
        .i_din   (r_push_data),
        .i_pop   (w_pop),
        .o_dout  (sample_data),
        .o_valid (sample_valid),
        .o_full  (w_full),
        .o_level (fill_level)
    );

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx driven by a behavioural I2S codec model.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        audio_BCLK;
    logic        audio_ADCLRCK;
    logic        audio_ADCDAT;
    logic        enable;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        overflow_clear;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk_clk = ~clk_clk;

    i2s_adc_rx #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .audio_BCLK     (audio_BCLK),
        .audio_ADCLRCK  (audio_ADCLRCK),
        .audio_ADCDAT   (audio_ADCDAT),
        .enable         (enable),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each accepted beat is compared against the oldest expected frame.
    always @(negedge clk_clk) begin
        if (reset_reset_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("beat_data", 64'(sample_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // BCLK = clk/16; LRCK and data change while BCLK is low.
    task automatic bclk_cycle(input logic lr, input logic d);
        audio_ADCLRCK = lr;
        audio_ADCDAT  = d;
        #80;
        audio_BCLK = 1'b1;
        #80;
        audio_BCLK = 1'b0;
    endtask

    // Delay slot (driven high so a capture of it shows up), then MSB-first bits, then zero pad.
    task automatic send_chan(input logic lr, input logic [15:0] word, input int nbits, input int nper);
        bclk_cycle(lr, 1'b1);
        for (int i = 0; i < nper - 1; i++) begin
            bclk_cycle(lr, (i < nbits) ? word[15 - i] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                              input int nper, input bit expect_it);
        if (expect_it) exp_q.push_back({l, r});
        send_chan(1'b0, l, nbits, nper);
        send_chan(1'b1, r, nbits, nper);
    endtask

    task automatic idle_gap();
        enable = 1'b0;
        repeat (3) bclk_cycle(1'b1, 1'b0);
        enable = 1'b1;
    endtask

    task automatic align();
        @(posedge clk_clk);
        #2;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk_clk);
            t++;
        end
        repeat (4) @(negedge clk_clk);
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_reset_n  = 1'b0;
        enable         = 1'b0;
        sample_ready   = 1'b0;
        audio_BCLK     = 1'b0;
        audio_ADCLRCK  = 1'b1;
        audio_ADCDAT   = 1'b0;
        overflow_clear = 1'b0;
        repeat (5) @(posedge clk_clk);
        #2;
        reset_reset_n = 1'b1;
        align();

        check_eq("rst_data", 64'(sample_data), 64'd0);
        check_eq("rst_valid", 64'(sample_valid), 64'd0);
        check_eq("rst_fill", 64'(fill_level), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);

        // Basic full-width frame.
        sample_ready = 1'b1;
        idle_gap();
        send_frame(16'hA5C3, 16'h1234, 16, 32, 1'b1);
        wait_drain("t1_drain");
        check_eq("t1_ovf", 64'(overflow), 64'd0);
        check_eq("t1_fill", 64'(fill_level), 64'd0);

        // Enable raised in the middle of a right channel.
        enable = 1'b0;
        repeat (4) bclk_cycle(1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) enable = 1'b1;
            bclk_cycle(1'b1, 1'b1);
        end
        send_frame(16'h0F0F, 16'hF00D, 16, 32, 1'b1);
        wait_drain("t2_drain");
        check_eq("t2_fill", 64'(fill_level), 64'd0);

        // Short 12-bit channels are left-aligned.
        idle_gap();
        send_frame(16'hFFF0, 16'hABC0, 12, 13, 1'b1);
        send_frame(16'h1230, 16'h7FF0, 12, 13, 1'b1);
        bclk_cycle(1'b0, 1'b0);
        bclk_cycle(1'b0, 1'b0);
        wait_drain("t3_drain");

        // Back-pressure for 10 frames: the last two are dropped.
        align();
        sample_ready = 1'b0;
        idle_gap();
        for (int f = 0; f < 10; f++) begin
            send_frame(16'h1000 + 16'(f), 16'hE000 + 16'(f * 257), 16, 20, f < 8);
        end
        repeat (20) @(negedge clk_clk);
        check_eq("t4_fill", 64'(fill_level), 64'd8);
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        check_eq("t4_valid", 64'(sample_valid), 64'd1);
        check_eq("t4_head", 64'(sample_data), {32'd0, 16'h1000, 16'hE000});
        align();
        sample_ready = 1'b1;
        wait_drain("t4_drain");
        check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);
        align();
        overflow_clear = 1'b1;
        align();
        overflow_clear = 1'b0;
        @(negedge clk_clk);
        check_eq("t4_ovf_clear", 64'(overflow), 64'd0);

        // Full FIFO with a pop in the push cycle.
        align();
        sample_ready = 1'b0;
        idle_gap();
        for (int f = 0; f < 8; f++) begin
            send_frame(16'h2000 + 16'(f), 16'h3100 + 16'(f), 16, 20, 1'b1);
        end
        repeat (20) @(negedge clk_clk);
        check_eq("t5_fill_pre", 64'(fill_level), 64'd8);
        fork
            send_frame(16'h2008, 16'h3108, 16, 20, 1'b1);
            begin : t5_watch
                int t;
                t = 0;
                @(posedge clk_clk);
                #1;
                while (dut.r_push !== 1'b1 && t < 3000) begin
                    @(posedge clk_clk);
                    #1;
                    t++;
                end
                check_eq("t5_push_seen", 64'(t < 3000), 64'd1);
                sample_ready = 1'b1;
                @(posedge clk_clk);
                #1;
                sample_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk_clk);
        check_eq("t5_fill", 64'(fill_level), 64'd8);
        check_eq("t5_ovf", 64'(overflow), 64'd0);
        align();
        sample_ready = 1'b1;
        wait_drain("t5_drain");

        // Reset mid-SHIFT, then a clean frame.
        align();
        sample_ready = 1'b0;
        idle_gap();
        send_frame(16'h7777, 16'h8888, 16, 20, 1'b0);
        repeat (10) @(negedge clk_clk);
        check_eq("t6_fill_pre", 64'(fill_level), 64'd1);
        fork
            send_frame(16'hDEAD, 16'hBEEF, 16, 20, 1'b0);
            begin
                #(160 * 7);
                reset_reset_n = 1'b0;
                #40;
                reset_reset_n = 1'b1;
                check_eq("t6_data", 64'(sample_data), 64'd0);
                check_eq("t6_valid", 64'(sample_valid), 64'd0);
                check_eq("t6_fill", 64'(fill_level), 64'd0);
                check_eq("t6_ovf", 64'(overflow), 64'd0);
            end
        join
        send_frame(16'h5A5A, 16'hC3C3, 16, 20, 1'b1);
        align();
        sample_ready = 1'b1;
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
